// File: rtl/csi2_packet_parser.sv
// Reassembles lane-aligned CSI-2 bytes into packet order, decodes the header, and emits sync pulses and the long-packet payload.
// Outputs are registered (1 clk_byte latency). data_valid dropping mid-packet aborts the packet, and there is no backpressure.
module csi2_packet_parser #(
    parameter int NUM_LANES      = 2,
    parameter int MAX_WORD_COUNT = 4096
) (
    input  logic                   clk_byte,
    input  logic                   RESETn,
    input  logic [8*NUM_LANES-1:0] data,
    input  logic                   data_valid,
    output logic [8*NUM_LANES-1:0] payload,
    output logic [NUM_LANES-1:0]   payload_keep,
    output logic                   payload_valid,
    output logic                   payload_last,
    output logic [5:0]             data_type,
    output logic [1:0]             virtual_channel,
    output logic [15:0]            word_count,
    output logic                   frame_start,
    output logic                   frame_end,
    output logic                   line_start,
    output logic                   line_end,
    output logic                   packet_start,
    output logic                   err_oversize,
    output logic                   err_truncated
);

    generate
        if (!(NUM_LANES == 1 || NUM_LANES == 2 || NUM_LANES == 4)) begin : g_bad_lanes
            $error("csi2_packet_parser: NUM_LANES must be 1, 2 or 4");
        end
    endgenerate

    localparam int          HDR_BEATS = 4 / NUM_LANES;
    localparam logic [1:0]  HDR_LAST  = 2'(HDR_BEATS - 1);
    localparam logic [15:0] NL16      = 16'(NUM_LANES);
    localparam logic [31:0] MAX_WC    = 32'(MAX_WORD_COUNT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HEADER,
        S_PAYLOAD,
        S_FOOTER,
        S_WAIT_END
    } state_t;

    state_t      state, state_nx;
    logic [1:0]  hcnt, hcnt_nx;
    logic [23:0] hdr, hdr_nx;
    logic [15:0] rem, rem_nx;
    logic [1:0]  crc_left, crc_nx;

    logic [8*NUM_LANES-1:0] payload_nx;
    logic [NUM_LANES-1:0]   keep_nx;
    logic        pvld_nx, plast_nx;
    logic [5:0]  dt_nx;
    logic [1:0]  vc_nx;
    logic [15:0] wc_nx;
    logic        fs_nx, fe_nx, ls_nx, le_nx, pstart_nx, eovr_nx, etrunc_nx;

    logic [1:0]  beat_idx;
    logic [23:0] hdr_asm;
    logic        hdr_done;
    logic [15:0] spare;
    int          idx;

    // Header bytes land at byte index beat*NUM_LANES+lane; the ECC byte (index 3) is dropped.
    always_comb begin
        beat_idx = (state == S_HEADER) ? hcnt : 2'd0;
        hdr_asm  = hdr;
        idx      = 0;
        for (int k = 0; k < NUM_LANES; k++) begin
            idx = int'(beat_idx) * NUM_LANES + k;
            if (idx < 3) begin
                hdr_asm[idx*8 +: 8] = data[8*k +: 8];
            end
        end
        hdr_done = (beat_idx == HDR_LAST);
    end

    always_comb begin
        state_nx   = state;
        hcnt_nx    = hcnt;
        hdr_nx     = hdr;
        rem_nx     = rem;
        crc_nx     = crc_left;
        payload_nx = '0;
        keep_nx    = '0;
        pvld_nx    = 1'b0;
        plast_nx   = 1'b0;
        dt_nx      = data_type;
        vc_nx      = virtual_channel;
        wc_nx      = word_count;
        fs_nx      = 1'b0;
        fe_nx      = 1'b0;
        ls_nx      = 1'b0;
        le_nx      = 1'b0;
        pstart_nx  = 1'b0;
        eovr_nx    = 1'b0;
        etrunc_nx  = 1'b0;
        spare      = '0;

        case (state)
            S_IDLE: begin
                if (data_valid) begin
                    hdr_nx   = hdr_asm;
                    hcnt_nx  = 2'd1;
                    state_nx = S_HEADER;
                end
            end
            S_HEADER: begin
                if (!data_valid) begin
                    etrunc_nx = 1'b1;
                    hcnt_nx   = 2'd0;
                    state_nx  = S_IDLE;
                end else begin
                    hdr_nx  = hdr_asm;
                    hcnt_nx = hcnt + 2'd1;
                end
            end
            S_PAYLOAD: begin
                if (!data_valid) begin
                    etrunc_nx = 1'b1;
                    state_nx  = S_IDLE;
                end else begin
                    payload_nx = data;
                    pvld_nx    = 1'b1;
                    if (rem <= NL16) begin
                        plast_nx = 1'b1;
                        for (int k = 0; k < NUM_LANES; k++) begin
                            keep_nx[k] = (16'(k) < rem);
                        end
                        rem_nx = '0;
                        // CRC bytes fill the unused lanes of the final beat first.
                        spare = NL16 - rem;
                        if (spare >= 16'd2) begin
                            state_nx = S_WAIT_END;
                        end else begin
                            crc_nx   = 2'd2 - spare[1:0];
                            state_nx = S_FOOTER;
                        end
                    end else begin
                        keep_nx = '1;
                        rem_nx  = rem - NL16;
                    end
                end
            end
            S_FOOTER: begin
                if (!data_valid) begin
                    etrunc_nx = 1'b1;
                    state_nx  = S_IDLE;
                end else if ({14'b0, crc_left} <= NL16) begin
                    state_nx = S_WAIT_END;
                end else begin
                    crc_nx = crc_left - 2'(NUM_LANES);
                end
            end
            S_WAIT_END: begin
                if (!data_valid) begin
                    state_nx = S_IDLE;
                end
            end
            default: state_nx = S_IDLE;
        endcase

        if (data_valid && (state == S_IDLE || state == S_HEADER) && hdr_done) begin
            hcnt_nx   = 2'd0;
            dt_nx     = hdr_asm[5:0];
            vc_nx     = hdr_asm[7:6];
            wc_nx     = hdr_asm[23:8];
            pstart_nx = 1'b1;
            if (hdr_asm[5:0] <= 6'h0F) begin
                case (hdr_asm[5:0])
                    6'h00:   fs_nx = 1'b1;
                    6'h01:   fe_nx = 1'b1;
                    6'h02:   ls_nx = 1'b1;
                    6'h03:   le_nx = 1'b1;
                    default: ;
                endcase
                state_nx = S_WAIT_END;
            end else if (32'(hdr_asm[23:8]) > MAX_WC) begin
                eovr_nx  = 1'b1;
                state_nx = S_WAIT_END;
            end else if (hdr_asm[23:8] == 16'd0) begin
                crc_nx   = 2'd2;
                state_nx = S_FOOTER;
            end else begin
                rem_nx   = hdr_asm[23:8];
                state_nx = S_PAYLOAD;
            end
        end
    end

    always_ff @(posedge clk_byte or negedge RESETn) begin
        if (!RESETn) begin
            state           <= S_IDLE;
            hcnt            <= '0;
            hdr             <= '0;
            rem             <= '0;
            crc_left        <= '0;
            payload         <= '0;
            payload_keep    <= '0;
            payload_valid   <= 1'b0;
            payload_last    <= 1'b0;
            data_type       <= '0;
            virtual_channel <= '0;
            word_count      <= '0;
            frame_start     <= 1'b0;
            frame_end       <= 1'b0;
            line_start      <= 1'b0;
            line_end        <= 1'b0;
            packet_start    <= 1'b0;
            err_oversize    <= 1'b0;
            err_truncated   <= 1'b0;
        end else begin
            state           <= state_nx;
            hcnt            <= hcnt_nx;
            hdr             <= hdr_nx;
            rem             <= rem_nx;
            crc_left        <= crc_nx;
            payload         <= payload_nx;
            payload_keep    <= keep_nx;
            payload_valid   <= pvld_nx;
            payload_last    <= plast_nx;
            data_type       <= dt_nx;
            virtual_channel <= vc_nx;
            word_count      <= wc_nx;
            frame_start     <= fs_nx;
            frame_end       <= fe_nx;
            line_start      <= ls_nx;
            line_end        <= le_nx;
            packet_start    <= pstart_nx;
            err_oversize    <= eovr_nx;
            err_truncated   <= etrunc_nx;
        end
    end

endmodule
